// File: rtl/pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// pc_redirect_ctrl
//
// Owns the fetch program counter and picks the next PC each cycle: sequential
// (PC+4) or a jal / jalr / taken-branch target from the execute stage.
// Every accepted redirect raises FLUSH for FLUSH_CYCLES non-stalled cycles.
// A misaligned control-flow target is trapped to MTVEC, and the offending
// address is captured in BAD_ADDR.
//
// Parameters:
//   RESET_VEC     PC value loaded on reset
//   FLUSH_CYCLES  non-stalled cycles FLUSH stays high after a redirect (1..7)
//   CNT_W         width of o_redirect_cnt
//
// Ports:
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_stall           hold PC / flush counter / state; no redirect accepted
//   i_ex_valid        execute-stage instruction valid
//   i_ex_jal          execute instruction is JAL
//   i_ex_jalr         execute instruction is JALR
//   i_ex_branch       execute instruction is a conditional branch
//   i_br_taken        branch condition true (qualifies i_ex_branch)
//   i_tgt_jal         jal target
//   i_tgt_jalr        raw jalr target (bit 0 cleared internally)
//   i_tgt_branch      branch target
//   i_mtvec           trap vector
//   o_pc              current fetch address (registered)
//   o_pc_sel          next-PC source, combinational: 0 seq, 1 jal, 2 jalr,
//                     3 branch, 4 trap
//   o_flush           squash younger instructions (registered)
//   o_misalign        one-cycle pulse after a trapped target (registered)
//   o_bad_addr        last misaligned target (registered)
//   o_redirect_cnt    accepted redirects including traps; wraps
// -----------------------------------------------------------------------------
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_stall,
    input  logic             i_ex_valid,
    input  logic             i_ex_jal,
    input  logic             i_ex_jalr,
    input  logic             i_ex_branch,
    input  logic             i_br_taken,
    input  logic [31:0]      i_tgt_jal,
    input  logic [31:0]      i_tgt_jalr,
    input  logic [31:0]      i_tgt_branch,
    input  logic [31:0]      i_mtvec,
    output logic [31:0]      o_pc,
    output logic [2:0]       o_pc_sel,
    output logic             o_flush,
    output logic             o_misalign,
    output logic [31:0]      o_bad_addr,
    output logic [CNT_W-1:0] o_redirect_cnt
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_JAL    = 3'd1,
        SEL_JALR   = 3'd2,
        SEL_BRANCH = 3'd3,
        SEL_TRAP   = 3'd4
    } pc_sel_t;

    // A 3-bit counter covers the whole legal FLUSH_CYCLES range of 1..7.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t           r_state;
    logic [2:0]       r_flush_cnt;
    logic [31:0]      r_pc;
    logic             r_flush;
    logic             r_misalign;
    logic [31:0]      r_bad_addr;
    logic [CNT_W-1:0] r_redirect_cnt;

    logic             w_ex_ok;
    logic             w_take_jal;
    logic             w_take_jalr;
    logic             w_take_branch;
    logic             w_redirect;
    logic             w_misalign;
    logic [31:0]      w_jalr_eff;
    logic [31:0]      w_tgt;
    pc_sel_t          w_pc_sel;

    // Redirect decode. The FLUSH state and a stall both mask the execute
    // stage entirely, so the priority chain only sees a qualified request.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_tgt         = i_tgt_branch;
        w_pc_sel      = SEL_SEQ;

        w_ex_ok       = (r_state == ST_RUN) && !i_stall && i_ex_valid;
        w_take_jal    = w_ex_ok && i_ex_jal;
        w_take_jalr   = w_ex_ok && !i_ex_jal && i_ex_jalr;
        w_take_branch = w_ex_ok && !i_ex_jal && !i_ex_jalr && i_ex_branch && i_br_taken;
        w_redirect    = w_take_jal || w_take_jalr || w_take_branch;

        // jalr drops bit 0 of the computed address before use.
        w_jalr_eff    = i_tgt_jalr & 32'hFFFF_FFFE;

        if (w_take_jal) begin
            w_tgt = i_tgt_jal;
        end else if (w_take_jalr) begin
            w_tgt = w_jalr_eff;
        end

        w_misalign = w_redirect && (w_tgt[1:0] != 2'b00);

        if (w_misalign) begin
            w_pc_sel = SEL_TRAP;
        end else if (w_take_jal) begin
            w_pc_sel = SEL_JAL;
        end else if (w_take_jalr) begin
            w_pc_sel = SEL_JALR;
        end else if (w_take_branch) begin
            w_pc_sel = SEL_BRANCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_RUN;
            r_flush_cnt    <= 3'd0;
            r_pc           <= RESET_VEC;
            r_flush        <= 1'b0;
            r_misalign     <= 1'b0;
            r_bad_addr     <= 32'h0000_0000;
            r_redirect_cnt <= '0;
        end else begin
            // The trap indicator is a single-cycle pulse even across stalls.
            r_misalign <= 1'b0;

            if (i_stall) begin
                // Everything else holds; FLUSH keeps its level while stalled.
            end else if (w_redirect) begin
                r_pc           <= w_misalign ? i_mtvec : w_tgt;
                r_misalign     <= w_misalign;
                if (w_misalign) begin
                    r_bad_addr <= w_tgt;
                end
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
                r_state        <= ST_FLUSH;
                r_flush_cnt    <= FLUSH_LOAD;
                r_flush        <= 1'b1;
            end else begin
                r_pc <= r_pc + 32'd4;
                if (r_state == ST_FLUSH) begin
                    // Leaving on the count of 1 keeps FLUSH high for exactly
                    // FLUSH_CYCLES non-stalled cycles.
                    if (r_flush_cnt <= 3'd1) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= 3'd0;
                        r_flush     <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
            end
        end
    end

    assign o_pc           = r_pc;
    assign o_pc_sel       = w_pc_sel;
    assign o_flush        = r_flush;
    assign o_misalign     = r_misalign;
    assign o_bad_addr     = r_bad_addr;
    assign o_redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_redirect_ctrl
//
// Directed testbench for pc_redirect_ctrl. A second instance with a 4-bit
// redirect counter shares all inputs so counter wrap is reachable quickly.
// -----------------------------------------------------------------------------
module tb_pc_redirect_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        ex_valid;
    logic        ex_jal;
    logic        ex_jalr;
    logic        ex_branch;
    logic        br_taken;
    logic [31:0] tgt_jal;
    logic [31:0] tgt_jalr;
    logic [31:0] tgt_branch;
    logic [31:0] mtvec;

    logic [31:0] pc;
    logic [2:0]  pc_sel;
    logic        flush;
    logic        misalign;
    logic [31:0] bad_addr;
    logic [15:0] redirect_cnt;

    logic [31:0] s_pc;
    logic [2:0]  s_pc_sel;
    logic        s_flush;
    logic        s_misalign;
    logic [31:0] s_bad_addr;
    logic [3:0]  s_redirect_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    pc_redirect_ctrl #(
        .RESET_VEC    (32'h0000_0000),
        .FLUSH_CYCLES (2),
        .CNT_W        (16)
    ) u_dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_stall        (stall),
        .i_ex_valid     (ex_valid),
        .i_ex_jal       (ex_jal),
        .i_ex_jalr      (ex_jalr),
        .i_ex_branch    (ex_branch),
        .i_br_taken     (br_taken),
        .i_tgt_jal      (tgt_jal),
        .i_tgt_jalr     (tgt_jalr),
        .i_tgt_branch   (tgt_branch),
        .i_mtvec        (mtvec),
        .o_pc           (pc),
        .o_pc_sel       (pc_sel),
        .o_flush        (flush),
        .o_misalign     (misalign),
        .o_bad_addr     (bad_addr),
        .o_redirect_cnt (redirect_cnt)
    );

    pc_redirect_ctrl #(
        .RESET_VEC    (32'h0000_0000),
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) u_dut_small (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_stall        (stall),
        .i_ex_valid     (ex_valid),
        .i_ex_jal       (ex_jal),
        .i_ex_jalr      (ex_jalr),
        .i_ex_branch    (ex_branch),
        .i_br_taken     (br_taken),
        .i_tgt_jal      (tgt_jal),
        .i_tgt_jalr     (tgt_jalr),
        .i_tgt_branch   (tgt_branch),
        .i_mtvec        (mtvec),
        .o_pc           (s_pc),
        .o_pc_sel       (s_pc_sel),
        .o_flush        (s_flush),
        .o_misalign     (s_misalign),
        .o_bad_addr     (s_bad_addr),
        .o_redirect_cnt (s_redirect_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        stall      = 1'b0;
        ex_valid   = 1'b0;
        ex_jal     = 1'b0;
        ex_jalr    = 1'b0;
        ex_branch  = 1'b0;
        br_taken   = 1'b0;
    endtask

    // Runs the cycles after a redirect: checks PC and FLUSH each edge.
    // Expected PCs are target, +4, +8 with FLUSH 1,1,0 for FLUSH_CYCLES=2.
    task automatic test_flush_window(input string name, input logic [31:0] base);
        logic [31:0] exp_pc;
        clear_ex();
        for (int k = 1; k <= 2; k++) begin
            tick();
            exp_pc = base + 32'(4 * k);
            n_vec++;
            if (pc !== exp_pc) begin
                n_miss++;
                $display("FAIL %s_pc[%0d]: got %h want %h", name, k, pc, exp_pc);
            end
            n_vec++;
            if (flush !== (k == 1)) begin
                n_miss++;
                $display("FAIL %s_flush[%0d]: got %b want %b", name, k, flush, (k == 1));
            end
        end
    endtask

    task automatic test_reset();
        clear_ex();
        tgt_jal    = 32'h0;
        tgt_jalr   = 32'h0;
        tgt_branch = 32'h0;
        mtvec      = 32'h0000_0080;
        rst_n      = 1'b0;
        #2;
        n_vec++;
        if (pc !== 32'h0 || flush !== 1'b0 || misalign !== 1'b0 || bad_addr !== 32'h0
            || redirect_cnt !== 16'h0 || pc_sel !== 3'd0) begin
            n_miss++;
            $display("FAIL reset_state: got pc=%h flush=%b mis=%b bad=%h cnt=%h sel=%0d want all zero",
                     pc, flush, misalign, bad_addr, redirect_cnt, pc_sel);
        end
        #10;
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_vec++;
            if (pc !== 32'(4 * i) || flush !== 1'b0 || pc_sel !== 3'd0) begin
                n_miss++;
                $display("FAIL idle_seq[%0d]: got pc=%h flush=%b sel=%0d want pc=%h flush=0 sel=0",
                         i, pc, flush, pc_sel, 32'(4 * i));
            end
        end
    endtask

    task automatic test_jal();
        // PC is 0x10 here.
        ex_valid = 1'b1;
        ex_jal   = 1'b1;
        tgt_jal  = 32'h0000_0100;
        #1;
        n_vec++;
        if (pc_sel !== 3'd1) begin
            n_miss++;
            $display("FAIL jal_sel: got %0d want 1", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h100 || flush !== 1'b1 || redirect_cnt !== 16'(exp_cnt)) begin
            n_miss++;
            $display("FAIL jal_redirect: got pc=%h flush=%b cnt=%0d want pc=100 flush=1 cnt=%0d",
                     pc, flush, redirect_cnt, exp_cnt);
        end
        // A taken branch during the flush window must be ignored.
        ex_jal     = 1'b0;
        ex_branch  = 1'b1;
        br_taken   = 1'b1;
        tgt_branch = 32'h0000_0300;
        #1;
        n_vec++;
        if (pc_sel !== 3'd0) begin
            n_miss++;
            $display("FAIL flush_ignore_sel: got %0d want 0", pc_sel);
        end
        tick();
        n_vec++;
        if (pc !== 32'h104 || flush !== 1'b1) begin
            n_miss++;
            $display("FAIL flush_ignore_pc: got pc=%h flush=%b want pc=104 flush=1", pc, flush);
        end
        tick();
        n_vec++;
        if (pc !== 32'h108 || flush !== 1'b0 || redirect_cnt !== 16'(exp_cnt)) begin
            n_miss++;
            $display("FAIL flush_end: got pc=%h flush=%b cnt=%0d want pc=108 flush=0 cnt=%0d",
                     pc, flush, redirect_cnt, exp_cnt);
        end
        clear_ex();
    endtask

    task automatic test_jalr_misalign();
        // PC is 0x108; 0x203 with bit 0 cleared is 0x202, still misaligned.
        ex_valid = 1'b1;
        ex_jalr  = 1'b1;
        tgt_jalr = 32'h0000_0203;
        #1;
        n_vec++;
        if (pc_sel !== 3'd4) begin
            n_miss++;
            $display("FAIL jalr_trap_sel: got %0d want 4", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h80 || misalign !== 1'b1 || bad_addr !== 32'h202 || flush !== 1'b1) begin
            n_miss++;
            $display("FAIL jalr_trap: got pc=%h mis=%b bad=%h flush=%b want pc=80 mis=1 bad=202 flush=1",
                     pc, misalign, bad_addr, flush);
        end
        n_vec++;
        if (redirect_cnt !== 16'(exp_cnt)) begin
            n_miss++;
            $display("FAIL jalr_trap_cnt: got %0d want %0d", redirect_cnt, exp_cnt);
        end
        clear_ex();
        tick();
        n_vec++;
        if (misalign !== 1'b0 || pc !== 32'h84 || bad_addr !== 32'h202) begin
            n_miss++;
            $display("FAIL misalign_pulse: got mis=%b pc=%h bad=%h want mis=0 pc=84 bad=202",
                     misalign, pc, bad_addr);
        end
        tick();
        n_vec++;
        if (pc !== 32'h88 || flush !== 1'b0) begin
            n_miss++;
            $display("FAIL trap_flush_end: got pc=%h flush=%b want pc=88 flush=0", pc, flush);
        end
    endtask

    task automatic test_priority();
        // JAL beats a simultaneous taken branch.
        ex_valid   = 1'b1;
        ex_jal     = 1'b1;
        ex_branch  = 1'b1;
        br_taken   = 1'b1;
        tgt_jal    = 32'h0000_0040;
        tgt_branch = 32'h0000_0080;
        #1;
        n_vec++;
        if (pc_sel !== 3'd1) begin
            n_miss++;
            $display("FAIL prio_jal_sel: got %0d want 1", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h40) begin
            n_miss++;
            $display("FAIL prio_jal_pc: got %h want 40", pc);
        end
        test_flush_window("prio_jal", 32'h40);

        // Branch not taken: plain sequential step, no flush.
        ex_valid   = 1'b1;
        ex_branch  = 1'b1;
        br_taken   = 1'b0;
        tgt_branch = 32'h0000_0500;
        #1;
        n_vec++;
        if (pc_sel !== 3'd0) begin
            n_miss++;
            $display("FAIL br_not_taken_sel: got %0d want 0", pc_sel);
        end
        tick();
        n_vec++;
        if (pc !== 32'h4C || flush !== 1'b0 || redirect_cnt !== 16'(exp_cnt)) begin
            n_miss++;
            $display("FAIL br_not_taken: got pc=%h flush=%b cnt=%0d want pc=4c flush=0 cnt=%0d",
                     pc, flush, redirect_cnt, exp_cnt);
        end

        // Flags without EX_VALID are ignored.
        clear_ex();
        ex_jal  = 1'b1;
        tgt_jal = 32'h0000_0900;
        #1;
        n_vec++;
        if (pc_sel !== 3'd0) begin
            n_miss++;
            $display("FAIL invalid_sel: got %0d want 0", pc_sel);
        end
        tick();
        n_vec++;
        if (pc !== 32'h50) begin
            n_miss++;
            $display("FAIL invalid_pc: got %h want 50", pc);
        end

        // JALR beats a taken branch; 0x601 resolves to aligned 0x600.
        clear_ex();
        ex_valid   = 1'b1;
        ex_jalr    = 1'b1;
        ex_branch  = 1'b1;
        br_taken   = 1'b1;
        tgt_jalr   = 32'h0000_0601;
        #1;
        n_vec++;
        if (pc_sel !== 3'd2) begin
            n_miss++;
            $display("FAIL prio_jalr_sel: got %0d want 2", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h600 || misalign !== 1'b0) begin
            n_miss++;
            $display("FAIL prio_jalr_pc: got pc=%h mis=%b want pc=600 mis=0", pc, misalign);
        end
        test_flush_window("prio_jalr", 32'h600);

        // Taken branch alone.
        ex_valid   = 1'b1;
        ex_branch  = 1'b1;
        br_taken   = 1'b1;
        tgt_branch = 32'h0000_0700;
        #1;
        n_vec++;
        if (pc_sel !== 3'd3) begin
            n_miss++;
            $display("FAIL branch_sel: got %0d want 3", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h700 || redirect_cnt !== 16'(exp_cnt)) begin
            n_miss++;
            $display("FAIL branch_pc: got pc=%h cnt=%0d want pc=700 cnt=%0d", pc, redirect_cnt, exp_cnt);
        end
        test_flush_window("branch", 32'h700);
    endtask

    task automatic test_stall_flush();
        // Stall in RUN blocks the redirect and holds PC.
        stall    = 1'b1;
        ex_valid = 1'b1;
        ex_jal   = 1'b1;
        tgt_jal  = 32'h0000_0900;
        #1;
        n_vec++;
        if (pc_sel !== 3'd0) begin
            n_miss++;
            $display("FAIL stall_run_sel: got %0d want 0", pc_sel);
        end
        tick();
        n_vec++;
        if (pc !== 32'h708 || redirect_cnt !== 16'(exp_cnt) || flush !== 1'b0) begin
            n_miss++;
            $display("FAIL stall_run_hold: got pc=%h cnt=%0d flush=%b want pc=708 cnt=%0d flush=0",
                     pc, redirect_cnt, flush, exp_cnt);
        end
        stall = 1'b0;
        #1;
        n_vec++;
        if (pc_sel !== 3'd1) begin
            n_miss++;
            $display("FAIL stall_release_sel: got %0d want 1", pc_sel);
        end
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h900 || flush !== 1'b1) begin
            n_miss++;
            $display("FAIL stall_redirect: got pc=%h flush=%b want pc=900 flush=1", pc, flush);
        end
        clear_ex();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (pc !== 32'h900 || flush !== 1'b1) begin
                n_miss++;
                $display("FAIL stall_flush_hold[%0d]: got pc=%h flush=%b want pc=900 flush=1",
                         k, pc, flush);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if (pc !== 32'h904 || flush !== 1'b1) begin
            n_miss++;
            $display("FAIL stall_flush_last: got pc=%h flush=%b want pc=904 flush=1", pc, flush);
        end
        tick();
        n_vec++;
        if (pc !== 32'h908 || flush !== 1'b0) begin
            n_miss++;
            $display("FAIL stall_flush_drop: got pc=%h flush=%b want pc=908 flush=0", pc, flush);
        end
    endtask

    task automatic test_misalign_stall();
        // Misaligned JAL target, then a stall: MISALIGN still clears.
        ex_valid = 1'b1;
        ex_jal   = 1'b1;
        tgt_jal  = 32'h0000_0901;
        tick();
        exp_cnt++;
        n_vec++;
        if (pc !== 32'h80 || misalign !== 1'b1 || bad_addr !== 32'h901) begin
            n_miss++;
            $display("FAIL jal_trap: got pc=%h mis=%b bad=%h want pc=80 mis=1 bad=901",
                     pc, misalign, bad_addr);
        end
        clear_ex();
        stall = 1'b1;
        tick();
        n_vec++;
        if (misalign !== 1'b0 || pc !== 32'h80 || flush !== 1'b1) begin
            n_miss++;
            $display("FAIL misalign_stall: got mis=%b pc=%h flush=%b want mis=0 pc=80 flush=1",
                     misalign, pc, flush);
        end
        stall = 1'b0;
        tick();
        tick();
        n_vec++;
        if (pc !== 32'h88 || flush !== 1'b0) begin
            n_miss++;
            $display("FAIL misalign_stall_end: got pc=%h flush=%b want pc=88 flush=0", pc, flush);
        end
    endtask

    task automatic test_pc_wrap();
        ex_valid = 1'b1;
        ex_jal   = 1'b1;
        tgt_jal  = 32'hFFFF_FFF4;
        tick();
        exp_cnt++;
        test_flush_window("wrap", 32'hFFFF_FFF4);
        tick();
        n_vec++;
        if (pc !== 32'h0000_0000 || flush !== 1'b0) begin
            n_miss++;
            $display("FAIL pc_wrap: got pc=%h flush=%b want pc=0 flush=0", pc, flush);
        end
    endtask

    task automatic test_cnt_wrap();
        logic [3:0] exp_small;
        for (int i = 0; i < 16; i++) begin
            ex_valid = 1'b1;
            ex_jal   = 1'b1;
            tgt_jal  = 32'h0000_1000;
            tick();
            exp_cnt++;
            exp_small = 4'(exp_cnt);
            n_vec++;
            if (redirect_cnt !== 16'(exp_cnt) || s_redirect_cnt !== exp_small) begin
                n_miss++;
                $display("FAIL cnt_wrap[%0d]: got cnt=%0d small=%0d want cnt=%0d small=%0d",
                         i, redirect_cnt, s_redirect_cnt, exp_cnt, exp_small);
            end
            clear_ex();
            tick();
            tick();
        end
    endtask

    task automatic test_reset_midflush();
        ex_valid = 1'b1;
        ex_jal   = 1'b1;
        tgt_jal  = 32'h0000_2002;
        tick();
        n_vec++;
        if (flush !== 1'b1 || misalign !== 1'b1 || bad_addr !== 32'h2002) begin
            n_miss++;
            $display("FAIL pre_reset_trap: got flush=%b mis=%b bad=%h want flush=1 mis=1 bad=2002",
                     flush, misalign, bad_addr);
        end
        clear_ex();
        #1;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_vec++;
        if (pc !== 32'h0 || flush !== 1'b0 || misalign !== 1'b0 || bad_addr !== 32'h0
            || redirect_cnt !== 16'h0 || s_redirect_cnt !== 4'h0) begin
            n_miss++;
            $display("FAIL async_reset: got pc=%h flush=%b mis=%b bad=%h cnt=%0d small=%0d want all zero",
                     pc, flush, misalign, bad_addr, redirect_cnt, s_redirect_cnt);
        end
        #3;
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (pc !== 32'h4 || flush !== 1'b0 || redirect_cnt !== 16'h0) begin
            n_miss++;
            $display("FAIL post_reset: got pc=%h flush=%b cnt=%0d want pc=4 flush=0 cnt=0",
                     pc, flush, redirect_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_jal();
        test_jalr_misalign();
        test_priority();
        test_stall_flush();
        test_misalign_stall();
        test_pc_wrap();
        test_cnt_wrap();
        test_reset_midflush();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Owns the program counter and sequences next-PC selection for the MCU core. Each cycle it chooses between sequential fetch (PC+4) and the jal/jalr/branch targets produced by the branch address generator. It also raises a pipeline flush after every redirect and traps misaligned control-flow targets to MTVEC. It sits between the execute-stage decode/branch-condition logic and the instruction-fetch address port.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded on reset
FLUSH_CYCLES, 2, number of non-stalled cycles FLUSH stays high after a redirect (legal range 1..7)
CNT_W, 16, width of REDIRECT_CNT

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST_N  input  1  asynchronous active-low reset
STALL  input  1  hold PC and flush counter this cycle; no redirect is accepted
EX_VALID  input  1  execute-stage instruction is valid
EX_JAL  input  1  execute instruction is JAL
EX_JALR  input  1  execute instruction is JALR
EX_BRANCH  input  1  execute instruction is a conditional branch
BR_TAKEN  input  1  branch condition true (qualifies EX_BRANCH only)
TGT_JAL  input  32  jal target (PC + J-imm)
TGT_JALR  input  32  jalr target (rs1 + I-imm), raw
TGT_BRANCH  input  32  branch target (PC + B-imm)
MTVEC  input  32  trap vector
PC  output  32  current fetch address (registered)
PC_SEL  output  3  next-PC source this cycle, combinational: 0 seq, 1 jal, 2 jalr, 3 branch, 4 trap
FLUSH  output  1  squash younger instructions (registered)
MISALIGN  output  1  one-cycle pulse: misaligned target trapped (registered)
BAD_ADDR  output  32  last misaligned target (registered)
REDIRECT_CNT  output  CNT_W  count of accepted redirects, including traps; wraps

Behaviour:
- Reset (async, RST_N=0): PC=RESET_VEC, state RUN, FLUSH=0, MISALIGN=0, BAD_ADDR=0, REDIRECT_CNT=0, flush counter=0.
- States:
  - RUN: EX inputs are honoured.
  - FLUSH: EX_VALID is ignored and treated as 0.
- Redirect request (RUN, !STALL, EX_VALID): selected by priority JAL > JALR > BRANCH&BR_TAKEN. More than one flag set is legal; the lowest-priority flags are ignored.
- JALR effective target = {TGT_JALR[31:1],1'b0}.
- Misalignment check: effective target[1:0] != 0 → trap. PC_SEL=4, next PC=MTVEC, BAD_ADDR<=effective target, MISALIGN=1 for exactly the following cycle.
- Aligned redirect: PC<=effective target; PC_SEL=1/2/3.
- No redirect: PC_SEL=0; PC<=PC+4 if !STALL, else PC holds. Addition is mod 2^32; 32'hFFFF_FFFC wraps to 0.
- Latency: redirect visible on PC one cycle after the request cycle; FLUSH rises on that same edge.
- Every accepted redirect or trap:
  - REDIRECT_CNT+1, wrapping at 2^CNT_W.
  - State→FLUSH, counter loaded with FLUSH_CYCLES.
- FLUSH state:
  - FLUSH=1; PC advances PC+4 when !STALL.
  - Counter decrements only on !STALL cycles.
  - When counter reaches 1 with !STALL, the next state is RUN and FLUSH drops on that edge. FLUSH is therefore high for exactly FLUSH_CYCLES non-stalled cycles.
- STALL=1 in any state: PC, counter, state and REDIRECT_CNT hold. PC_SEL=0; MISALIGN still clears after its one cycle.
- RST_N asserted mid-flush or mid-trap: immediate return to reset values; no pending redirect survives.
- PC_SEL is purely combinational from current state and inputs. It is 0 whenever no redirect is accepted, including in FLUSH and during STALL.

Test Plan:
- Reset then 4 idle cycles, RESET_VEC=0 → PC 0,4,8,C,10; FLUSH=0; PC_SEL=0.
- At PC=0x10, EX_VALID+EX_JAL, TGT_JAL=0x100 → PC_SEL=1 that cycle; next PC=0x100. FLUSH high for 2 cycles (PC 0x100, 0x104); REDIRECT_CNT=1. An EX_BRANCH+BR_TAKEN during flush is ignored.
- EX_JALR, TGT_JALR=0x203 → PC=0x202 → misaligned: PC_SEL=4, PC=MTVEC (0x80), MISALIGN single pulse, BAD_ADDR=0x202.
- EX_JAL and EX_BRANCH+BR_TAKEN together, TGT_JAL=0x40, TGT_BRANCH=0x80 → PC=0x40, PC_SEL=1. Then EX_BRANCH with BR_TAKEN=0 → PC+4, no flush.
- Redirect followed by STALL=1 for 3 cycles in FLUSH → PC and FLUSH hold; FLUSH is high for 5 cycles total and drops after 2 non-stalled cycles.
- PC=0xFFFF_FFFC, no redirect → PC wraps to 0. REDIRECT_CNT preloaded via 65536 redirects wraps to 0. RST_N pulsed low mid-flush → all outputs return to reset values asynchronously.
